// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in serial-out serializer.
package piso_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit-counter width: enough to hold WIDTH-1, never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_datapath.sv
// Shift register for the serializer: parallel load, then shift toward the output end with zero fill.
module piso_shift_datapath #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] pi_data,
  output logic             out_bit
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;

  generate
    if (WIDTH == 1) begin : g_single
      assign sr_shifted = '0;
    end else if (MSB_FIRST) begin : g_msb
      assign sr_shifted = {sr[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign sr_shifted = {1'b0, sr[WIDTH-1:1]};
    end
  endgenerate

  // NOTE: sr carries data only, so it has no reset; the control side masks
  // out_bit whenever no word is in flight.
  always_ff @(posedge clk) begin
    if (load) begin
      sr <= pi_data;
    end else if (shift) begin
      sr <= sr_shifted;
    end
  end

  assign out_bit = MSB_FIRST ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage with valid/ready on both sides and first/last framing.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pi_data,
  input  logic             pi_valid,
  output logic             pi_ready,
  output logic             so_data,
  output logic             so_valid,
  input  logic             so_ready,
  output logic             so_first,
  output logic             so_last,
  output logic             busy
);

  localparam int             CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_e        state;
  logic [CW-1:0] bit_cnt;
  logic          shifting;
  logic          xfer;
  logic          accept;
  logic          out_bit;

  assign shifting = (state == ST_SHIFT);
  assign so_valid = shifting;
  assign busy     = shifting;
  assign so_first = shifting && (bit_cnt == '0);
  assign so_last  = shifting && (bit_cnt == LAST_CNT);
  assign so_data  = shifting && out_bit;
  assign xfer     = shifting && so_ready;

  // so_ready reaches pi_ready combinationally so the next word can load on
  // the same edge that retires the last bit of the current one.
  assign pi_ready = !rst && (!shifting || (so_last && so_ready));
  assign accept   = pi_valid && pi_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
    end else if (accept) begin
      state   <= ST_SHIFT;
      bit_cnt <= '0;
    end else if (xfer) begin
      if (so_last) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  piso_shift_datapath #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_datapath (
    .clk    (clk),
    .load   (accept),
    .shift  (xfer && !so_last),
    .pi_data(pi_data),
    .out_bit(out_bit)
  );

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out stage that sits directly downstream of the 4-bit PIPO register. It takes the register's parallel output word and emits it one bit per accepted transfer on a serial link. Valid/ready handshakes on both sides let the upstream register be reloaded back-to-back without bubbles. Framing flags mark the first and last bit of each word.

Parameters:
WIDTH, 4, word width in bits; legal range WIDTH >= 1.
MSB_FIRST, 1, 1 = shift out pi_data[WIDTH-1] first; 0 = shift out pi_data[0] first.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; synchronous, active-high.
pi_data  input  WIDTH  parallel word from the PIPO register.
pi_valid  input  1  pi_data holds a word to serialize.
pi_ready  output  1  word is accepted on a cycle where pi_valid && pi_ready.
so_data  output  1  current serial bit.
so_valid  output  1  so_data is valid.
so_ready  input  1  downstream accepts the bit on a cycle where so_valid && so_ready.
so_first  output  1  so_data is bit 0 of the word in transmission order.
so_last  output  1  so_data is the final bit of the word.
busy  output  1  a word is loaded and not yet fully transmitted.

Behaviour:
- Reset: while rst=1 at a clock edge, the block goes to IDLE. so_valid, so_data, so_first, so_last and busy all become 0, and the bit counter is cleared. pi_ready is forced to 0 while rst is high.
- Reset mid-word: the word in progress is discarded and no further bits are emitted. The first cycle after rst deasserts is IDLE with pi_ready=1.
- FSM states are IDLE and SHIFT.
- IDLE:
  - so_valid=0, busy=0, pi_ready=1.
  - On pi_valid, load the shift register with pi_data, set bit_cnt=0 and go to SHIFT.
- SHIFT:
  - so_valid=1, busy=1.
  - so_data is the shift-register bit at the output end: MSB when MSB_FIRST=1, LSB otherwise.
  - so_first = (bit_cnt==0).
  - so_last = (bit_cnt==WIDTH-1).
- Transfer in SHIFT: on so_valid && so_ready with not so_last, shift by one toward the output end (zero fill) and increment bit_cnt.
- Stall: while so_ready=0, so_data, so_first, so_last and bit_cnt hold stable.
- Last-bit transfer (so_last && so_ready):
  - If pi_valid=1: load the new word, clear bit_cnt and remain in SHIFT. This is a zero-bubble back-to-back load.
  - If pi_valid=0: go to IDLE.
- pi_ready:
  - pi_ready = !rst && (IDLE || (SHIFT && so_last && so_ready)).
  - This is a combinational path from so_ready to pi_ready, and it is intentional.
  - In SHIFT with !(so_last && so_ready), pi_ready=0; pi_valid is ignored and pi_data is not sampled.
- Latency: a word accepted at edge N produces its first bit with so_valid=1 in the cycle after edge N. A word takes exactly WIDTH accepted transfers. Sustained throughput is one word per WIDTH cycles with so_ready held at 1.
- WIDTH=1: so_first and so_last are both 1 on the single bit. The counter is one bit wide but still used.
- bit_cnt width is max(1, $clog2(WIDTH)). It never exceeds WIDTH-1, so it never wraps.
- so_data is 0 in IDLE.

Decomposition:
- Package piso_pkg holds:
  - state enum {ST_IDLE, ST_SHIFT};
  - the function cnt_w(WIDTH) = max(1, $clog2(WIDTH)).
- Sub-module piso_shift_datapath(WIDTH, MSB_FIRST):
  - inputs: load, shift, pi_data;
  - output: out_bit;
  - contains the shift register only.
- FSM, counter and handshake logic stay in piso_serializer.

Test Plan:
- Basic MSB-first: WIDTH=4, so_ready=1, one pulse pi_data=4'b1011 -> so_data 1,0,1,1 on the next 4 cycles; so_first on cycle 1, so_last on cycle 4; then IDLE with pi_ready=1.
- LSB-first: MSB_FIRST=0, pi_data=4'b1011 -> so_data 1,1,0,1.
- Back-to-back: pi_valid held high with 4'b1100 then 4'b0011 -> 8 consecutive valid bits 1,1,0,0,0,0,1,1 with no gap. pi_ready pulses only on the last bit of word 1.
- Backpressure: load 4'b1010 and drop so_ready for 3 cycles after bit 2 -> so_data holds 0 and so_first=0, so_last=0 stay stable; bits 3 and 4 (1,0) follow on release; total valid cycles = 7.
- Busy ignore: pi_valid=1 with 4'b1111 during bit 2 of 4'b0000 -> pi_ready=0, and the output stays 0,0,0,0 until the last-bit transfer.
- Reset mid-word: assert rst during bit 3 of 4'b1001 -> next cycle so_valid=0, busy=0; after release pi_ready=1, and a fresh 4'b0110 serializes correctly as 0,1,1,0.
